// File: rtl/sync_cnt_pkg.sv
// Shared constants and helpers for the synchronous T-flip-flop counter.
package sync_cnt_pkg;

  localparam int DEFAULT_WIDTH = 3;

  // Terminal-count constant for a counter of the given width (1..32).
  function automatic logic [31:0] all_ones(input int width);
    if (width >= 32) return '1;
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/sync_t_counter_t_ff.sv
// Single T flip-flop, async active-high reset to 0; toggles on clk when t=1.
module t_ff (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  logic q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (t) q_d = ~q_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= 1'b0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/sync_t_counter.sv
// Synchronous up-counter from a chain of T flip-flops sharing one clock.
// Optional terminal-count output tc is enabled by defining SYNC_CNT_TC_EN.
module sync_t_counter
  import sync_cnt_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             t,
  output logic [WIDTH-1:0] q
`ifdef SYNC_CNT_TC_EN
  ,
  output logic             tc
`endif
);

  localparam logic [31:0] TC_VAL = all_ones(WIDTH);

  // Toggle enables: each bit flips only when t and every lower bit are 1.
  logic [WIDTH-1:0] en;

  assign en[0] = t;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i > 0) begin : g_chain
      assign en[i] = en[i-1] & q[i-1];
    end
    t_ff u_tff (
      .clk (clk),
      .rst (rst),
      .t   (en[i]),
      .q   (q[i])
    );
  end

`ifdef SYNC_CNT_TC_EN
  // Combinational so a cascaded stage sees it in the cycle before the wrap.
  assign tc = t & (q == TC_VAL[WIDTH-1:0]);
`endif

endmodule

// File: tb/tb_sync_t_counter.sv
// Scoreboard bench for sync_t_counter: 3-bit and 4-bit instances on shared stimulus.
module tb_sync_t_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       t;
  logic [2:0] q3;
  logic [3:0] q4;
`ifdef SYNC_CNT_TC_EN
  logic       tc3, tc4;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] q3;
    logic [3:0] q4;
  } exp_t;

  exp_t sb[$];
  logic [2:0] m3;
  logic [3:0] m4;

  always #5 clk = ~clk;

  sync_t_counter #(.WIDTH(3)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .t   (t),
    .q   (q3)
`ifdef SYNC_CNT_TC_EN
    ,
    .tc  (tc3)
`endif
  );

  sync_t_counter #(.WIDTH(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .t   (t),
    .q   (q4)
`ifdef SYNC_CNT_TC_EN
    ,
    .tc  (tc4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive t away from the edge, advance one edge, then compare against the model.
  task automatic cyc(input string tag, input logic tv);
    exp_t e;
    t = tv;
`ifdef SYNC_CNT_TC_EN
    #0;
    chk({tag, "_tc3"}, {31'd0, tc3}, {31'd0, tv & (m3 == 3'd7)});
    chk({tag, "_tc4"}, {31'd0, tc4}, {31'd0, tv & (m4 == 4'd15)});
`endif
    @(posedge clk);
    if (tv) begin
      m3 = m3 + 3'd1;
      m4 = m4 + 4'd1;
    end
    sb.push_back('{q3: m3, q4: m4});
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_q3"}, {29'd0, q3}, {29'd0, e.q3});
      chk({tag, "_q4"}, {28'd0, q4}, {28'd0, e.q4});
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_q3"}, {29'd0, q3}, 32'd0);
    chk({tag, "_q4"}, {28'd0, q4}, 32'd0);
`ifdef SYNC_CNT_TC_EN
    chk({tag, "_tc3"}, {31'd0, tc3}, 32'd0);
    chk({tag, "_tc4"}, {31'd0, tc4}, 32'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    t   = 1'b1;
    m3  = '0;
    m4  = '0;

    // Reset held from time 0 through the edge at 5, released at 12.
    #1;  chk_zero("rst_t1");
    #10; chk_zero("rst_t11");
    #1;  rst = 1'b0;

    // Count 1..7 on edges 15..75, wrap to 0 at 85, 1 at 95.
    for (int i = 0; i < 7; i++) cyc("count", 1'b1);
    chk("count_at7", {29'd0, q3}, 32'd7);
    cyc("wrap0", 1'b1);
    chk("wrap_is0", {29'd0, q3}, 32'd0);
    cyc("wrap1", 1'b1);

    // Hold at 3 for four edges, then resume.
    cyc("to2", 1'b1);
    cyc("to3", 1'b1);
    for (int i = 0; i < 4; i++) cyc("hold", 1'b0);
    chk("hold_at3", {29'd0, q3}, 32'd3);
    cyc("resume", 1'b1);
    chk("resume_at4", {29'd0, q3}, 32'd4);
    cyc("to5", 1'b1);

    // Asynchronous reset pulse between edges.
    #2; rst = 1'b1;
    #1; chk_zero("async_rst");
    m3 = '0;
    m4 = '0;
    #1; rst = 1'b0;
    cyc("post_rst", 1'b1);
    chk("post_rst_at1", {29'd0, q3}, 32'd1);

    // Reset dominates t for five edges.
    #2; rst = 1'b1;
    t = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1; chk_zero("rst_dom");
    end
    m3 = '0;
    m4 = '0;
    #2; rst = 1'b0;

    // Full 4-bit sweep 1..15 then wrap to 0; 3-bit wraps twice alongside.
    for (int i = 0; i < 16; i++) cyc("w4", 1'b1);
    chk("w4_wrap", {28'd0, q4}, 32'd0);
    cyc("w4_after", 1'b1);

    chk("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
